// File: rtl/lif_neuron_update.sv
// Purpose : leaky integrate-and-fire update over a vector of N pooled activations (one SNN timestep per start).
// Latency : 3 cycles per neuron (READ, CALC, WRITE); done returns high on the edge that retires the last element.
// Backpressure: none; memories are fixed one-cycle-read, single-cycle-write slaves, and start is ignored while busy.
//
// Ports:
//   clk, reset                       clock and synchronous active-high reset
//   start / done                     pass handshake; start sampled only while idle, done high when idle
//   length, threshold                neuron count and signed firing threshold, both latched at start
//   src_*                            pooled-activation read port (data valid one cycle after address)
//   mem_*                            membrane read/write port (same address is read then written back)
//   spike_*                          spike-word write port (16'd1 on spike, 16'd0 otherwise)
//   spike_count                      spikes emitted in the current or most recent pass
module lif_neuron_update #(
    parameter int                 LEAK_SHIFT = 3,
    parameter logic signed [15:0] V_RESET    = 16'sd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        done,
    input  logic [13:0] length,
    input  logic [15:0] threshold,
    input  logic [13:0] src_start_address,
    output logic [13:0] src_address,
    input  logic [15:0] src_readdata,
    input  logic [13:0] mem_start_address,
    output logic [13:0] mem_address,
    input  logic [15:0] mem_readdata,
    output logic [15:0] mem_writedata,
    output logic        mem_write_en,
    input  logic [13:0] spike_start_address,
    output logic [13:0] spike_address,
    output logic [15:0] spike_writedata,
    output logic        spike_write_en,
    output logic [13:0] spike_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_CALC  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [13:0]        index;
    logic [13:0]        len_q;
    logic signed [15:0] thr_q;

    logic               accept;
    logic               last;

    // Leak/integrate datapath, 18 bits wide so the sum can never wrap
    // before it is saturated back to 16 bits.
    logic signed [17:0] v_ext;
    logic signed [17:0] in_ext;
    logic signed [17:0] leak;
    logic signed [17:0] sum;
    logic signed [15:0] sat;
    logic               fire;

    assign accept = start && (length != 14'd0);
    assign last   = (index == (len_q - 14'd1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_READ;
            S_READ:  state_nxt = S_CALC;
            S_CALC:  state_nxt = S_WRITE;
            S_WRITE: state_nxt = last ? S_IDLE : S_READ;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Neuron arithmetic; only consumed in CALC, outputs are registered
    // so readdata never reaches a port combinationally.
    // ------------------------------------------------------------------
    always_comb begin
        v_ext  = {{2{mem_readdata[15]}}, mem_readdata};
        in_ext = {{2{src_readdata[15]}}, src_readdata};
        leak   = v_ext >>> LEAK_SHIFT;
        sum    = v_ext - leak + in_ext;
        if (sum > 18'sd32767) begin
            sat = 16'sh7fff;
        end else if (sum < -18'sd32768) begin
            sat = 16'sh8000;
        end else begin
            sat = sum[15:0];
        end
        // Saturation happens first so a clipped sum can still fire.
        fire = (sat >= thr_q);
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            done            <= 1'b1;
            src_address     <= src_start_address;
            mem_address     <= mem_start_address;
            spike_address   <= spike_start_address;
            mem_writedata   <= 16'd0;
            spike_writedata <= 16'd0;
            mem_write_en    <= 1'b0;
            spike_write_en  <= 1'b0;
            spike_count     <= 14'd0;
            index           <= 14'd0;
            len_q           <= 14'd0;
            thr_q           <= 16'sd0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Addresses follow the base inputs so the first READ
                    // already presents element 0.
                    src_address   <= src_start_address;
                    mem_address   <= mem_start_address;
                    spike_address <= spike_start_address;
                    if (accept) begin
                        len_q       <= length;
                        thr_q       <= threshold;
                        index       <= 14'd0;
                        spike_count <= 14'd0;
                        done        <= 1'b0;
                    end
                end

                S_READ: begin
                    // Addresses held; read data appears during CALC.
                end

                S_CALC: begin
                    if (fire) begin
                        spike_writedata <= 16'd1;
                        mem_writedata   <= V_RESET;
                        spike_count     <= spike_count + 14'd1;
                    end else begin
                        spike_writedata <= 16'd0;
                        mem_writedata   <= sat;
                    end
                    mem_write_en   <= 1'b1;
                    spike_write_en <= 1'b1;
                end

                S_WRITE: begin
                    mem_write_en   <= 1'b0;
                    spike_write_en <= 1'b0;
                    if (last) begin
                        done          <= 1'b1;
                        src_address   <= src_start_address;
                        mem_address   <= mem_start_address;
                        spike_address <= spike_start_address;
                    end else begin
                        // 14-bit adds wrap naturally at the top of memory.
                        index         <= index + 14'd1;
                        src_address   <= src_address + 14'd1;
                        mem_address   <= mem_address + 14'd1;
                        spike_address <= spike_address + 14'd1;
                    end
                end

                default: begin
                    mem_write_en   <= 1'b0;
                    spike_write_en <= 1'b0;
                end
            endcase
        end
    end

endmodule
